// File: rtl/basicgates_df_mux_if.sv
// Operand/result bundle for basicgates_df_mux: the two operands and the six
// registered gate outputs, all WIDTH lanes wide.
interface basicgates_df_mux_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out_and;
    logic [WIDTH-1:0] out_or;
    logic [WIDTH-1:0] out_nand;
    logic [WIDTH-1:0] out_nor;
    logic [WIDTH-1:0] out_xor;
    logic [WIDTH-1:0] out_xnor;

    modport master (
        output a,
        output b,
        input  out_and,
        input  out_or,
        input  out_nand,
        input  out_nor,
        input  out_xor,
        input  out_xnor
    );

    modport slave (
        input  a,
        input  b,
        output out_and,
        output out_or,
        output out_nand,
        output out_nor,
        output out_xor,
        output out_xnor
    );
endinterface

// File: rtl/basicgates_df_mux.sv
// Registered bank of six two-input gates, each built as a 2:1 mux selected by
// operand a, with b, ~b or a constant on the data legs; one-cycle latency.
module basicgates_df_mux #(
    parameter int WIDTH = 1
) (
    input logic                clk,
    input logic                rst_n,
    basicgates_df_mux_if.slave bus
);

    function automatic logic mux2(input logic sel, input logic leg_hi, input logic leg_lo);
        return sel ? leg_hi : leg_lo;
    endfunction

    logic [WIDTH-1:0] and_d,  or_d,  nand_d,  nor_d,  xor_d,  xnor_d;
    logic [WIDTH-1:0] and_q,  or_q,  nand_q,  nor_q,  xor_q,  xnor_q;

    // Each lane picks its "a=1" or "a=0" leg independently; no cross-lane terms.
    always_comb begin
        and_d  = '0;
        or_d   = '0;
        nand_d = '0;
        nor_d  = '0;
        xor_d  = '0;
        xnor_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            and_d[i]  = mux2(bus.a[i], bus.b[i],  1'b0);
            or_d[i]   = mux2(bus.a[i], 1'b1,      bus.b[i]);
            nand_d[i] = mux2(bus.a[i], ~bus.b[i], 1'b1);
            nor_d[i]  = mux2(bus.a[i], 1'b0,      ~bus.b[i]);
            xor_d[i]  = mux2(bus.a[i], ~bus.b[i], bus.b[i]);
            xnor_d[i] = mux2(bus.a[i], bus.b[i],  ~bus.b[i]);
        end
    end

    // Reset clears every output to 0, so the complement pairs are both 0 until
    // the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_q  <= '0;
            or_q   <= '0;
            nand_q <= '0;
            nor_q  <= '0;
            xor_q  <= '0;
            xnor_q <= '0;
        end else begin
            and_q  <= and_d;
            or_q   <= or_d;
            nand_q <= nand_d;
            nor_q  <= nor_d;
            xor_q  <= xor_d;
            xnor_q <= xnor_d;
        end
    end

    assign bus.out_and  = and_q;
    assign bus.out_or   = or_q;
    assign bus.out_nand = nand_q;
    assign bus.out_nor  = nor_q;
    assign bus.out_xor  = xor_q;
    assign bus.out_xnor = xnor_q;

endmodule

// File: tb/tb_basicgates_df_mux.sv
// Directed and random checks of basicgates_df_mux at WIDTH=1 and WIDTH=4,
// with expected results queued at drive time and compared one edge later.
module tb_basicgates_df_mux;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    basicgates_df_mux_if #(.WIDTH(1)) bus1 ();
    basicgates_df_mux_if #(.WIDTH(4)) bus4 ();

    basicgates_df_mux #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    basicgates_df_mux #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // Gate order in every packed result: and, or, nand, nor, xor, xnor.
    typedef struct packed {
        logic [5:0][3:0] w;
        logic [5:0][3:0] n;
    } exp_t;

    exp_t  scoreboard[$];
    exp_t  last_exp;
    int    checks   = 0;
    int    failures = 0;
    string gate_names[6] = '{"and", "or", "nand", "nor", "xor", "xnor"};

    function automatic logic [5:0][3:0] gateModel(input logic [3:0] a, input logic [3:0] b);
        logic [5:0][3:0] r;
        r[0] = a & b;
        r[1] = a | b;
        r[2] = ~(a & b);
        r[3] = ~(a | b);
        r[4] = a ^ b;
        r[5] = ~(a ^ b);
        return r;
    endfunction

    function automatic logic [5:0][3:0] observedWide();
        logic [5:0][3:0] r;
        r[0] = bus4.out_and;
        r[1] = bus4.out_or;
        r[2] = bus4.out_nand;
        r[3] = bus4.out_nor;
        r[4] = bus4.out_xor;
        r[5] = bus4.out_xnor;
        return r;
    endfunction

    function automatic logic [5:0][3:0] observedNarrow();
        logic [5:0][3:0] r;
        r[0] = {3'b000, bus1.out_and};
        r[1] = {3'b000, bus1.out_or};
        r[2] = {3'b000, bus1.out_nand};
        r[3] = {3'b000, bus1.out_nor};
        r[4] = {3'b000, bus1.out_xor};
        r[5] = {3'b000, bus1.out_xnor};
        return r;
    endfunction

    task automatic compareVec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // The narrow DUT sees bit 0 of the wide operands; its expectations are
    // the model result masked to lane 0.
    task automatic applyStimulus(input logic [3:0] a4, input logic [3:0] b4);
        exp_t e;
        bus4.a = a4;
        bus4.b = b4;
        bus1.a = a4[0];
        bus1.b = b4[0];
        e.w = gateModel(a4, b4);
        e.n = gateModel(a4 & 4'b0001, b4 & 4'b0001);
        for (int g = 0; g < 6; g++) e.n[g] = e.n[g] & 4'b0001;
        scoreboard.push_back(e);
    endtask

    task automatic compareAll(input string tag, input exp_t e);
        logic [5:0][3:0] ow;
        logic [5:0][3:0] on;
        ow = observedWide();
        on = observedNarrow();
        for (int g = 0; g < 6; g++) begin
            compareVec({tag, "_", gate_names[g], "_w4"}, ow[g], e.w[g]);
            compareVec({tag, "_", gate_names[g], "_w1"}, on[g], e.n[g]);
        end
    endtask

    task automatic checkOutput(input string tag);
        if (scoreboard.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s observed=empty_scoreboard expected=pending_entry", tag);
        end else begin
            last_exp = scoreboard.pop_front();
            compareAll(tag, last_exp);
        end
    endtask

    task automatic checkHold(input string tag);
        compareAll(tag, last_exp);
    endtask

    task automatic checkReset(input string tag);
        logic [5:0][3:0] ow;
        logic [5:0][3:0] on;
        ow = observedWide();
        on = observedNarrow();
        for (int g = 0; g < 6; g++) begin
            compareVec({tag, "_", gate_names[g], "_w4"}, ow[g], 4'b0000);
            compareVec({tag, "_", gate_names[g], "_w1"}, on[g], 4'b0000);
        end
    endtask

    task automatic checkInvariants(input string tag);
        compareVec({tag, "_nand_w4"}, bus4.out_nand, ~bus4.out_and);
        compareVec({tag, "_nor_w4"},  bus4.out_nor,  ~bus4.out_or);
        compareVec({tag, "_xnor_w4"}, bus4.out_xnor, ~bus4.out_xor);
        compareVec({tag, "_nand_w1"}, {3'b000, bus1.out_nand}, {3'b000, ~bus1.out_and});
        compareVec({tag, "_nor_w1"},  {3'b000, bus1.out_nor},  {3'b000, ~bus1.out_or});
        compareVec({tag, "_xnor_w1"}, {3'b000, bus1.out_xnor}, {3'b000, ~bus1.out_xor});
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;

        rst_n  = 1'b0;
        bus4.a = 4'b0000;
        bus4.b = 4'b0000;
        bus1.a = 1'b0;
        bus1.b = 1'b0;

        @(negedge clk);
        #1 checkReset("reset");

        // Truth table on lane 0; release reset before the capturing edge.
        @(negedge clk);
        applyStimulus(4'b0000, 4'b0000);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("tt_00");
        applyStimulus(4'b0000, 4'b0001);
        stepCycle();
        checkOutput("tt_01");
        applyStimulus(4'b0001, 4'b0000);
        stepCycle();
        checkOutput("tt_10");
        applyStimulus(4'b0001, 4'b0001);
        stepCycle();
        checkOutput("tt_11");

        // Multi-lane pattern with hand-written expectations as well.
        applyStimulus(4'b1100, 4'b1010);
        stepCycle();
        checkOutput("wide");
        compareVec("wide_const_and",  bus4.out_and,  4'b1000);
        compareVec("wide_const_or",   bus4.out_or,   4'b1110);
        compareVec("wide_const_nand", bus4.out_nand, 4'b0111);
        compareVec("wide_const_nor",  bus4.out_nor,  4'b0001);
        compareVec("wide_const_xor",  bus4.out_xor,  4'b0110);
        compareVec("wide_const_xnor", bus4.out_xnor, 4'b1001);

        // Latency: a mid-cycle input change must not reach the outputs early.
        applyStimulus(4'b0000, 4'b0000);
        stepCycle();
        checkOutput("lat_00");
        applyStimulus(4'b1111, 4'b1111);
        #2 checkHold("lat_hold");
        stepCycle();
        checkOutput("lat_11");

        // Inputs glitched and restored between edges leave outputs alone.
        applyStimulus(4'b0101, 4'b0011);
        #1;
        bus4.a = 4'b1010;
        bus4.b = 4'b1100;
        bus1.a = 1'b0;
        bus1.b = 1'b0;
        #1 checkHold("glitch_hold");
        #1;
        bus4.a = 4'b0101;
        bus4.b = 4'b0011;
        bus1.a = 1'b1;
        bus1.b = 1'b1;
        stepCycle();
        checkOutput("glitch_after");

        // Asynchronous reset mid-cycle, then recapture on the first edge.
        applyStimulus(4'b1111, 4'b1111);
        stepCycle();
        checkOutput("pre_rst");
        applyStimulus(4'b1111, 4'b1111);
        #1 rst_n = 1'b0;
        #1 checkReset("async_rst");
        #1 rst_n = 1'b1;
        stepCycle();
        checkOutput("rst_release");

        for (int i = 0; i < 120; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            applyStimulus(ra, rb);
            stepCycle();
            checkOutput("rand");
            checkInvariants("inv");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
